timer_share_arbiter: RTL and testbench

Shares one 4-bit countdown timer between two requesting controllers, for example two intersection light controllers, so each no longer needs its own timer. A client raises a request with a duration in ticks. The block arbitrates round-robin, loads and runs the shared timer from an internal tick prescaler, and pulses `done` to the owning client when the count expires. It sits between the light-controller FSMs and the 1 Hz display/timing logic.

---
 rtl/timer_share_arbiter.sv | 136 +++++++++++++
 tb/tb_timer_share_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_share_arbiter.sv
// timer_share_arbiter
//   Shares a single 4-bit countdown timer between two requesting clients.
//   Requests are arbitrated round-robin. The winner's duration is latched at
//   grant, and the timer counts it down at one step per prescaler tick. The
//   owner receives a one-cycle done pulse on expiry. If the owner withdraws
//   its request while the timer is loading or running, the transaction is
//   aborted without a done pulse.
//
// Parameters
//   TICK_DIV  clk cycles per timer tick (>= 1)
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   req    in   [1:0] per-client request, held until done or withdrawn
//   dur0   in   [3:0] client 0 duration in ticks, sampled at grant
//   dur1   in   [3:0] client 1 duration in ticks, sampled at grant
//   gnt    out  [1:0] one-hot timer owner during LOAD and RUN
//   done   out  [1:0] one-cycle expiry pulse to the owner
//   busy   out  high whenever the arbiter is not idle
//   count  out  [3:0] current timer value, 0 when not running
//   tick   out  prescaler pulse, only in RUN
module timer_share_arbiter #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] dur0,
  input  logic [3:0] dur1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic [3:0] count,
  output logic       tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state;
  logic [1:0]    req_q;   // requests as sampled on the previous edge
  logic          last;    // client served (or aborted) most recently
  logic          owner;   // current timer owner
  logic [3:0]    dur_q;
  logic [PW-1:0] presc;

  logic win;
  logic owner_req;

  // Requests are registered before use. All arbitration and abort decisions
  // therefore act on the value sampled one edge earlier, which keeps req off
  // every output path.
  always_comb begin
    win = ~last;
    case (req_q)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~last;
    endcase
  end

  assign owner_req = req_q[owner];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_q <= '0;
      last  <= 1'b1;
      owner <= 1'b0;
      dur_q <= '0;
      presc <= '0;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
      tick  <= 1'b0;
    end else begin
      req_q <= req;
      done  <= '0;
      tick  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_q) begin
            owner <= win;
            dur_q <= win ? dur1 : dur0;
            gnt   <= win ? 2'b10 : 2'b01;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!owner_req) begin
            state <= IDLE;
            gnt   <= '0;
            count <= '0;
            presc <= '0;
            last  <= owner;
          end else begin
            count <= dur_q;
            presc <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Withdrawal beats expiry; expiry is tested before any tick so the
          // count never wraps below zero.
          if (!owner_req) begin
            state <= IDLE;
            gnt   <= '0;
            count <= '0;
            presc <= '0;
            last  <= owner;
          end else if (count == '0) begin
            state <= DONE;
            gnt   <= '0;
            done  <= owner ? 2'b10 : 2'b01;
            presc <= '0;
          end else if (presc == PRESC_MAX) begin
            presc <= '0;
            tick  <= 1'b1;
            count <= count - 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_share_arbiter.sv
// tb_timer_share_arbiter
//   Scoreboarded bench for timer_share_arbiter with TICK_DIV = 2. Stimulus
//   tasks predict each done pulse (client, cycle, tick count) from the timing
//   rules and queue it. A free-running monitor pops an entry on every done
//   pulse and compares it.
module tb_timer_share_arbiter;

  localparam int unsigned TD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] dur0;
  logic [3:0] dur1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [3:0] count;
  logic       tick;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        m_last;          // model of the round-robin pointer

  typedef struct {
    logic [1:0]  who;
    int unsigned at;
    int unsigned ticks;
  } exp_t;

  exp_t sb[$];

  timer_share_arbiter #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .dur0  (dur0),
    .dur1  (dur1),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count),
    .tick  (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  // Expected done events. The request is first sampled at edge e0. Each
  // transaction finishes 3 + d*TD edges after its own sampling edge. The next
  // sampling edge follows one edge after that.
  task automatic model_push(input logic [1:0] pat, input bit hold, input int n,
                            input int unsigned e0);
    logic [1:0]  pend;
    int unsigned t;
    int unsigned d;
    logic        w;
    exp_t        e;
    pend = pat;
    t    = e0;
    for (int k = 0; k < n; k++) begin
      w       = (pend == 2'b11) ? ~m_last : pend[1];
      d       = w ? int'(dur1) : int'(dur0);
      e.who   = w ? 2'b10 : 2'b01;
      e.at    = t + 3 + d * TD;
      e.ticks = d;
      sb.push_back(e);
      t      = t + 4 + d * TD;
      m_last = w;
      if (!hold) pend[w] = 1'b0;
    end
  endtask

  // Holds the requests until n done pulses have arrived. In non-hold mode a
  // client drops its request on its own done pulse. The optional late value
  // overwrites a client's duration once that client is granted.
  task automatic run_episode(input logic [1:0] pat, input logic [3:0] d0,
                             input logic [3:0] d1, input bit hold, input int n,
                             input bit late, input logic [3:0] late_val);
    int got;
    int budget;
    got    = 0;
    budget = 0;
    dur0   = d0;
    dur1   = d1;
    model_push(pat, hold, n, cyc + 1);
    req = pat;
    while (got < n && budget < 400) begin
      step();
      budget++;
      if (late && gnt[0]) dur0 = late_val;
      if (late && gnt[1]) dur1 = late_val;
      if (done != 2'b00) begin
        got++;
        if (!hold) req = req & ~done;
        else if (got == n) req = '0;
      end
    end
    if (got < n) begin
      fail_now("episode_timeout");
      sb.delete();
    end
    req = '0;
  endtask

  // Withdraws the request once the count shows c (1 <= c < d). Two edges
  // later the block must be idle and cleared, and it must issue no done pulse.
  task automatic run_abort(input logic w, input logic [3:0] d, input logic [3:0] c);
    int budget;
    budget = 0;
    if (w) dur1 = d; else dur0 = d;
    req = w ? 2'b10 : 2'b01;
    while (!(busy && gnt == req && count == c) && budget < 200) begin
      step();
      budget++;
    end
    if (budget >= 200) fail_now("abort_count_timeout");
    req = '0;
    step();
    step();
    check("abort_gnt", gnt, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_count", count, 4'd0);
    m_last = w;
  endtask

  // Monitor: scoreboard pops on done pulses, plus per-cycle invariants.
  initial begin
    int unsigned ticks_seen;
    exp_t        e;
    ticks_seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ticks_seen = 0;
      end else begin
        if (gnt == 2'b11) check("gnt_onehot", gnt, 2'b01);
        if (tick) ticks_seen++;
        if (done != 2'b00) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=%b expected none (cycle %0d)", done, cyc);
          end else begin
            e = sb.pop_front();
            check("done_who", done, e.who);
            check("done_cycle", cyc, e.at);
            check("done_ticks", ticks_seen, e.ticks);
            check("gnt_at_done", gnt, 2'b00);
          end
          ticks_seen = 0;
        end else if (!busy) begin
          ticks_seen = 0;
        end
      end
    end
  end

  initial begin
    int unsigned e0;
    int          budget;
    logic [1:0]  pat;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [3:0]  dd;
    bit          hold;
    int          n;

    rst    = 1'b1;
    req    = '0;
    dur0   = '0;
    dur1   = '0;
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_tick", tick, 1'b0);
    rst = 1'b0;
    step();

    // Asynchronous reset in the middle of RUN.
    dur0   = 4'd7;
    req    = 2'b01;
    budget = 0;
    while (count != 4'd5 && budget < 100) begin
      step();
      budget++;
    end
    if (budget >= 100) fail_now("midrun_count_timeout");
    #3;
    rst = 1'b1;
    #1;
    check("midrst_gnt", gnt, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", count, 4'd0);
    check("midrst_tick", tick, 1'b0);
    sb.delete();
    m_last = 1'b1;
    req    = '0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Both requesting after reset: client 0 must win first.
    run_episode(2'b11, 4'd2, 4'd1, 1'b0, 2, 1'b0, 4'd0);
    wait_idle();

    // Contention, both held continuously: grant order 0,1,0,1.
    run_episode(2'b11, 4'd1, 4'd2, 1'b1, 4, 1'b0, 4'd0);
    wait_idle();
    step();

    // Single request with explicit count/gnt/busy timeline.
    dur0 = 4'd3;
    req  = 2'b01;
    e0   = cyc + 1;
    model_push(2'b01, 1'b0, 1, e0);
    step();
    step();
    check("single_gnt", gnt, 2'b01);
    step();
    check("single_count_e2", count, 4'd3);
    for (int j = 1; j <= 3; j++) begin
      step();
      step();
      check("single_count_step", count, 4'(3 - j));
    end
    step();
    check("single_busy_done", busy, 1'b1);
    req = '0;
    step();
    check("single_busy_drop", busy, 1'b0);
    step();

    // Zero duration: done three edges after sampling, no tick.
    run_episode(2'b10, 4'd0, 4'd0, 1'b0, 1, 1'b0, 4'd0);
    wait_idle();
    step();

    // Late duration change after the grant has no effect.
    run_episode(2'b01, 4'd2, 4'd0, 1'b0, 1, 1'b1, 4'd9);
    wait_idle();
    step();

    // Abort at count 3, then client 1 is favoured.
    run_abort(1'b0, 4'd5, 4'd3);
    step();
    dur0 = 4'd3;
    dur1 = 4'd1;
    e0   = cyc + 1;
    model_push(2'b11, 1'b0, 2, e0);
    req = 2'b11;
    step();
    step();
    check("post_abort_gnt", gnt, 2'b10);
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      if (done != 2'b00) req = req & ~done;
      step();
      budget++;
    end
    if (budget >= 200) fail_now("post_abort_timeout");
    req = '0;
    wait_idle();

    // Randomized episodes.
    for (int i = 0; i < 40; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 4) == 0) begin
        dd = 4'($urandom_range(2, 8));
        run_abort(1'($urandom_range(0, 1)), dd, 4'($urandom_range(1, int'(dd) - 1)));
      end else begin
        pat  = 2'($urandom_range(1, 3));
        d0   = 4'($urandom_range(0, 7));
        d1   = 4'($urandom_range(0, 7));
        hold = ($urandom_range(0, 3) == 0);
        n    = hold ? int'($urandom_range(2, 4)) : $countones(pat);
        run_episode(pat, d0, d1, hold, n, !hold && ($urandom_range(0, 1) == 1),
                    4'($urandom_range(0, 15)));
      end
    end

    wait_idle();
    repeat (4) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
